exu_stage: RTL and testbench
============================

// Module: exu_stage
// PURPOSE
//  Execute stage, directly upstream of the memory/writeback-prep stage. Latches one decoded instruction,
//  computes the ALU result or effective address, and performs the data-memory access via a req/rsp port.
//  Emits exe_to_mem_bus: load data pre-shifted to bit 0, plus the load-extension code for downstream.
//  Single-entry stage with valid/ready handshakes on both sides.
// PARAMETERS
//  REG_ADDR_WIDTH  5   register index width
//  ADDR_WIDTH      32  data-memory address width
//  DATA_WIDTH      32  datapath width; lane logic is defined for 32 only
// PORTS
//  clk              in   1        clock
//  rst              in   1        synchronous active-high reset
//  id_to_exe_valid  in   1        upstream instruction valid
//  exe_to_id_ready  out  1        stage can accept this cycle
//  id_to_exe_bus    in   3*DW+RA+10  {regW,regAddr,alu_op[3:0],src1,src2,store_data,load_inst[2:0],store_inst[1:0]}
//  exe_to_mem_valid out  1        result valid (state VALID)
//  mem_to_exe_ready in   1        downstream accepts
//  exe_to_mem_bus   out  2*DW+RA+4  {regW,regAddr,regData,load_inst,load_data}
//  exe_misalign     out  1        held instruction is a misaligned half/word access; qualified by exe_to_mem_valid
//  dmem_req_valid   out  1        memory request valid
//  dmem_req_ready   in   1        memory accepts request
//  dmem_wen         out  1        1 = store
//  dmem_addr        out  AW       word-aligned address {ea[AW-1:2],2'b00}
//  dmem_wdata       out  DW       store data shifted to lane
//  dmem_wstrb       out  4        byte strobes; 0 for loads
//  dmem_rsp_valid   in   1        response (load data or store ack); always accepted
//  dmem_rdata       in   DW       raw word read data
// BEHAVIOUR
//  Reset: state=EMPTY; exe_to_mem_valid=0, dmem_req_valid=0, regW=0, exe_misalign=0.
//  Encodings: load_inst 0 none,1 lb,2 lh,3 lw,4 lbu,5 lhu; store_inst 0 none,1 sb,2 sh,3 sw.
//  alu_op: 0 add,1 sub,2 and,3 or,4 xor,5 sll,6 srl,7 sra,8 slt,9 sltu,10 pass src2, others -> 0.
//   Shifts use src2[4:0]. Mem ops always use ea=src1+src2 (alu_op ignored); regData=ea.
//  exe_to_id_ready = (state==EMPTY) | (state==VALID & mem_to_exe_ready). Combinational; no dependence on id_to_exe_valid.
//  FSM states EMPTY, REQ, WAIT, VALID:
//   EMPTY/VALID, accept (valid&ready): mem op -> REQ; else -> VALID (latency 1 cycle).
//   VALID, downstream takes, no new accept -> EMPTY. Take + accept same cycle -> back-to-back, no bubble.
//   REQ: dmem_req_valid=1, all dmem_* stable until dmem_req_ready; on ready -> WAIT.
//   WAIT: on dmem_rsp_valid -> VALID. Load captures aligned data; store ignores rdata, load_data=0.
//   rsp only counted from the cycle after req handshake; rsp in EMPTY/REQ/VALID is ignored.
//  Lanes: sh=ea[1:0]*8. load_data = dmem_rdata >> sh.
//   wdata = store_data << sh; wstrb: sb 4'b0001<<ea[1:0], sh 4'b0011<<ea[1:0], sw 4'b1111.
//  Misalign: lh/lhu/sh with ea[0]=1, or lw/sw with ea[1:0]!=0.
//   Access still issued at word address; shifted lanes are truncated to 4 bits. exe_misalign=1 with the result.
//  Output bus is registered, stable while exe_to_mem_valid & ~mem_to_exe_ready. load_inst passes unchanged.
//  Reset mid-access (REQ/WAIT) -> EMPTY; a late dmem_rsp_valid after reset is ignored.
//  Mem op with both load_inst and store_inst nonzero: store takes priority; load_inst is forced to 0 on the bus.
// STRUCTURE
//  Package exu_pkg: ALU op codes, load/store encodings, FSM state enum, bus field offsets
//   (shared with decode and lsu stages).
//  Sub-module exu_alu: combinational (alu_op,src1,src2)->result. FSM, lanes and handshakes stay in exu_stage.
// TESTING
//  1 add: src1=5,src2=7,regW=1,regAddr=3 -> next cycle valid, bus regData=12, load_inst=0.
//  2 lbu: ea=0x8000_0003, rdata=0xAABBCCDD, req_ready after 2 cycles, rsp 1 later
//    -> dmem_addr 0x8000_0000, wstrb 0, load_data=0x000000AA, load_inst=4.
//  3 sh: ea=0x102, store_data=0x1234 -> wstrb 4'b1100, wdata 0x12340000, wen=1; VALID only after rsp.
//  4 backpressure: mem_to_exe_ready=0 for 3 cycles with next instr pending
//    -> bus stable, exe_to_id_ready=0; ready=1 -> take and accept same cycle.
//  5 misalign: lw ea=0x101 -> exe_misalign=1, dmem_addr 0x100. sltu src1=1,src2=0xFFFFFFFF -> regData=1.
//  6 rst in WAIT -> EMPTY, valid=0; rsp_valid next cycle ignored; next instruction completes normally.

Source files
------------

// File: rtl/exu_pkg.sv
// Shared definitions for the execute stage and its neighbours (decode, lsu).
//   - ALU op codes, load/store encodings
//   - FSM state enum for the execute stage
//   - Bit offsets of the fixed-width fields at the bottom of the
//     id->exe bus; wider fields are stacked above them by the consumer
//     using its own DATA_WIDTH / REG_ADDR_WIDTH.
package exu_pkg;

    // ALU operation codes (alu_op[3:0]); unlisted codes produce 0
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    // Load encodings (load_inst[2:0])
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;

    // Store encodings (store_inst[1:0])
    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    // Execute stage FSM
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } exu_state_e;

    // Fixed-width fields at the LSB end of id_to_exe_bus
    localparam int ALU_OP_W      = 4;
    localparam int LOAD_W        = 3;
    localparam int STORE_W       = 2;
    localparam int IN_STORE_LSB  = 0;
    localparam int IN_LOAD_LSB   = IN_STORE_LSB + STORE_W;
    localparam int IN_SDATA_LSB  = IN_LOAD_LSB + LOAD_W;

endpackage

// File: rtl/exu_alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   alu_op  in  4   operation code (exu_pkg ALU_*)
//   src1    in  DW  first operand
//   src2    in  DW  second operand; shifts use src2[4:0]
//   result  out DW  operation result, 0 for undefined codes
module exu_alu
    import exu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    output logic [DATA_WIDTH-1:0] result
);

    logic [4:0] shamt;
    assign shamt = src2[4:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = src1 + src2;
            ALU_SUB:  result = src1 - src2;
            ALU_AND:  result = src1 & src2;
            ALU_OR:   result = src1 | src2;
            ALU_XOR:  result = src1 ^ src2;
            ALU_SLL:  result = src1 << shamt;
            ALU_SRL:  result = src1 >> shamt;
            ALU_SRA:  result = $signed(src1) >>> shamt;
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (src1 < src2)};
            ALU_PASS: result = src2;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/exu_stage.sv
// Execute stage: latches one decoded instruction, computes the ALU result or
// effective address, performs the data-memory access and presents a
// registered result to the memory/writeback-prep stage.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_to_exe_valid/_bus         upstream instruction
//                                {regW,regAddr,alu_op,src1,src2,store_data,load_inst,store_inst}
//   exe_to_id_ready              stage can accept this cycle
//   exe_to_mem_valid/_bus        result {regW,regAddr,regData,load_inst,load_data}
//   mem_to_exe_ready             downstream accepts result
//   exe_misalign                 held instruction is a misaligned half/word access
//   dmem_req_*/dmem_wen/addr/wdata/wstrb   data-memory request
//   dmem_rsp_valid/dmem_rdata    data-memory response (always accepted)
//   dbg_state                    current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready; once raised, valid and its payload
// hold until the transfer. exe_to_id_ready is combinational from state and
// mem_to_exe_ready only. dmem responses are accepted unconditionally and are
// only meaningful in S_WAIT (the cycle after the request handshake onward).
module exu_stage
    import exu_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  id_to_exe_valid,
    output logic                                  exe_to_id_ready,
    input  logic [3*DATA_WIDTH+REG_ADDR_WIDTH+9:0] id_to_exe_bus,
    output logic                                  exe_to_mem_valid,
    input  logic                                  mem_to_exe_ready,
    output logic [2*DATA_WIDTH+REG_ADDR_WIDTH+3:0] exe_to_mem_bus,
    output logic                                  exe_misalign,
    output logic                                  dmem_req_valid,
    input  logic                                  dmem_req_ready,
    output logic                                  dmem_wen,
    output logic [ADDR_WIDTH-1:0]                 dmem_addr,
    output logic [DATA_WIDTH-1:0]                 dmem_wdata,
    output logic [3:0]                            dmem_wstrb,
    input  logic                                  dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                 dmem_rdata,
    output exu_state_e                            dbg_state
);

    localparam int DW = DATA_WIDTH;
    localparam int RA = REG_ADDR_WIDTH;

    // Field positions above the fixed-width LSB fields
    localparam int IN_SRC2_LSB = IN_SDATA_LSB + DW;
    localparam int IN_SRC1_LSB = IN_SRC2_LSB + DW;
    localparam int IN_OP_LSB   = IN_SRC1_LSB + DW;
    localparam int IN_RA_LSB   = IN_OP_LSB + ALU_OP_W;
    localparam int IN_REGW_BIT = IN_RA_LSB + RA;

    // ---------------- input field decode ----------------
    logic            in_regw;
    logic [RA-1:0]   in_ra;
    logic [3:0]      in_op;
    logic [DW-1:0]   in_src1, in_src2, in_sdata;
    logic [2:0]      in_load;
    logic [1:0]      in_store;

    assign in_store = id_to_exe_bus[IN_STORE_LSB +: STORE_W];
    assign in_load  = id_to_exe_bus[IN_LOAD_LSB  +: LOAD_W];
    assign in_sdata = id_to_exe_bus[IN_SDATA_LSB +: DW];
    assign in_src2  = id_to_exe_bus[IN_SRC2_LSB  +: DW];
    assign in_src1  = id_to_exe_bus[IN_SRC1_LSB  +: DW];
    assign in_op    = id_to_exe_bus[IN_OP_LSB    +: ALU_OP_W];
    assign in_ra    = id_to_exe_bus[IN_RA_LSB    +: RA];
    assign in_regw  = id_to_exe_bus[IN_REGW_BIT];

    // ---------------- execute datapath ----------------
    logic [DW-1:0] alu_res, ea, wdata_n;
    logic [4:0]    lane_sh;
    logic          is_store, is_load, is_mem, misalign_n;
    logic [3:0]    wstrb_n;

    exu_alu #(.DATA_WIDTH(DW)) u_alu (
        .alu_op (in_op),
        .src1   (in_src1),
        .src2   (in_src2),
        .result (alu_res)
    );

    // A store wins when decode marks both; the load is then dropped entirely.
    assign is_store = (in_store != ST_NONE);
    assign is_load  = (in_load != LD_NONE) && !is_store;
    assign is_mem   = is_store || is_load;
    assign ea       = in_src1 + in_src2;
    assign lane_sh  = {ea[1:0], 3'b000};
    // Shifts are width-bounded: lanes pushed past byte 3 simply fall off.
    assign wdata_n  = in_sdata << lane_sh;

    always_comb begin
        wstrb_n = 4'b0000;
        case (in_store)
            ST_SB:   wstrb_n = 4'b0001 << ea[1:0];
            ST_SH:   wstrb_n = 4'b0011 << ea[1:0];
            ST_SW:   wstrb_n = 4'b1111;
            default: wstrb_n = 4'b0000;
        endcase
    end

    always_comb begin
        misalign_n = 1'b0;
        if (is_store) begin
            misalign_n = ((in_store == ST_SH) && ea[0]) ||
                         ((in_store == ST_SW) && (ea[1:0] != 2'b00));
        end else if (is_load) begin
            misalign_n = (((in_load == LD_LH) || (in_load == LD_LHU)) && ea[0]) ||
                         ((in_load == LD_LW) && (ea[1:0] != 2'b00));
        end
    end

    // ---------------- FSM ----------------
    exu_state_e state_q, state_d;
    logic       accept;

    assign exe_to_id_ready = (state_q == S_EMPTY) ||
                             ((state_q == S_VALID) && mem_to_exe_ready);
    assign accept          = id_to_exe_valid && exe_to_id_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) state_d = is_mem ? S_REQ : S_VALID;
            end
            S_VALID: begin
                // accept here implies the result was also taken this cycle
                if (accept)                state_d = is_mem ? S_REQ : S_VALID;
                else if (mem_to_exe_ready) state_d = S_EMPTY;
            end
            S_REQ: begin
                if (dmem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dmem_rsp_valid) state_d = S_VALID;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    // ---------------- held instruction / result registers ----------------
    logic            out_regw;
    logic [RA-1:0]   out_ra;
    logic [DW-1:0]   out_data, out_load_data;
    logic [2:0]      out_load_inst;
    logic            out_misalign;
    logic            held_load;
    logic [1:0]      held_lane;
    logic [DW-1:0]   req_ea, req_wdata;
    logic [3:0]      req_wstrb;
    logic            req_wen;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_regw      <= 1'b0;
            out_ra        <= '0;
            out_data      <= '0;
            out_load_inst <= LD_NONE;
            out_load_data <= '0;
            out_misalign  <= 1'b0;
            held_load     <= 1'b0;
            held_lane     <= 2'b00;
            req_ea        <= '0;
            req_wdata     <= '0;
            req_wstrb     <= 4'b0000;
            req_wen       <= 1'b0;
        end else if (accept) begin
            out_regw      <= in_regw;
            out_ra        <= in_ra;
            out_data      <= is_mem ? ea : alu_res;
            out_load_inst <= is_store ? LD_NONE : in_load;
            out_load_data <= '0;
            out_misalign  <= misalign_n;
            held_load     <= is_load;
            held_lane     <= ea[1:0];
            req_ea        <= ea;
            req_wdata     <= is_store ? wdata_n : '0;
            req_wstrb     <= wstrb_n;
            req_wen       <= is_store;
        end else if ((state_q == S_WAIT) && dmem_rsp_valid && held_load) begin
            // raw word shifted so the addressed byte lands at bit 0; the
            // sign/zero extension is left to the next stage via load_inst
            out_load_data <= dmem_rdata >> {held_lane, 3'b000};
        end
    end

    // ---------------- outputs ----------------
    assign exe_to_mem_valid = (state_q == S_VALID);
    assign exe_to_mem_bus   = {out_regw, out_ra, out_data, out_load_inst, out_load_data};
    assign exe_misalign     = out_misalign;

    assign dmem_req_valid = (state_q == S_REQ);
    assign dmem_wen       = req_wen;
    assign dmem_addr      = {req_ea[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_wdata     = req_wdata;
    assign dmem_wstrb     = req_wstrb;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_exu_stage.sv
module tb_exu_stage;
  import exu_pkg::*;

  localparam int RA    = 5;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IN_W  = 3*DW+RA+10;
  localparam int OUT_W = 2*DW+RA+4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              id_to_exe_valid;
  logic              exe_to_id_ready;
  logic [IN_W-1:0]   id_to_exe_bus;
  logic              exe_to_mem_valid;
  logic              mem_to_exe_ready;
  logic [OUT_W-1:0]  exe_to_mem_bus;
  logic              exe_misalign;
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_wen;
  logic [AW-1:0]     dmem_addr;
  logic [DW-1:0]     dmem_wdata;
  logic [3:0]        dmem_wstrb;
  logic              dmem_rsp_valid;
  logic [DW-1:0]     dmem_rdata;
  exu_state_e        dbg_state;

  exu_stage #(.REG_ADDR_WIDTH(RA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_to_exe_valid  (id_to_exe_valid),
    .exe_to_id_ready  (exe_to_id_ready),
    .id_to_exe_bus    (id_to_exe_bus),
    .exe_to_mem_valid (exe_to_mem_valid),
    .mem_to_exe_ready (mem_to_exe_ready),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .exe_misalign     (exe_misalign),
    .dmem_req_valid   (dmem_req_valid),
    .dmem_req_ready   (dmem_req_ready),
    .dmem_wen         (dmem_wen),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_wstrb       (dmem_wstrb),
    .dmem_rsp_valid   (dmem_rsp_valid),
    .dmem_rdata       (dmem_rdata),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // entries are {misalign, exe_to_mem_bus}
  logic [OUT_W:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] mk_in(input logic regw, input logic [RA-1:0] ra,
      input logic [3:0] op, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
      input logic [DW-1:0] sd, input logic [2:0] li, input logic [1:0] si);
    return {regw, ra, op, s1, s2, sd, li, si};
  endfunction

  function automatic logic [OUT_W:0] mk_out(input logic mis, input logic regw,
      input logic [RA-1:0] ra, input logic [DW-1:0] d, input logic [2:0] li,
      input logic [DW-1:0] ld);
    return {mis, regw, ra, d, li, ld};
  endfunction

  // Output monitor: inputs only change just after posedge, so the negedge
  // sample matches what the next posedge will transfer.
  always @(negedge clk) begin
    if (!rst && exe_to_mem_valid && mem_to_exe_ready) begin
      check("out_expected_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("out_bus", {exe_misalign, exe_to_mem_bus}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until it is accepted.
  task automatic drive_id(input logic [IN_W-1:0] b);
    int   n;
    logic got;
    n = 0;
    id_to_exe_valid = 1'b1;
    id_to_exe_bus   = b;
    forever begin
      #1;
      got = exe_to_id_ready;
      tick();
      if (got) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", got, 1'b1);
        break;
      end
    end
    id_to_exe_valid = 1'b0;
  endtask

  // Called right after a mem-op accept: hold off req_ready for rdy_dly
  // cycles, then respond rsp_dly cycles after the request handshake.
  task automatic mem_serve(input string tag, input int rdy_dly, input int rsp_dly,
      input logic [DW-1:0] rdata, input logic [AW-1:0] e_addr, input logic e_wen,
      input logic [3:0] e_wstrb, input logic [DW-1:0] e_wdata);
    for (int i = 0; i <= rdy_dly; i++) begin
      dmem_req_ready = (i == rdy_dly);
      #1;
      check({tag, "_req_valid"}, dmem_req_valid, 1'b1);
      check({tag, "_addr"},      dmem_addr, e_addr);
      check({tag, "_wen"},       dmem_wen, e_wen);
      check({tag, "_wstrb"},     dmem_wstrb, e_wstrb);
      check({tag, "_wdata"},     dmem_wdata, e_wdata);
      check({tag, "_no_early_valid"}, exe_to_mem_valid, 1'b0);
      tick();
    end
    dmem_req_ready = 1'b0;
    for (int i = 0; i <= rsp_dly; i++) begin
      dmem_rsp_valid = (i == rsp_dly);
      dmem_rdata     = (i == rsp_dly) ? rdata : DW'($urandom);
      #1;
      check({tag, "_wait_not_valid"}, exe_to_mem_valid, 1'b0);
      check({tag, "_req_dropped"},    dmem_req_valid, 1'b0);
      tick();
    end
    dmem_rsp_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0]    alu_ops [10] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
                                  ALU_SRL, ALU_SRA, ALU_SLT, ALU_PASS, 4'd11};
  logic [DW-1:0] alu_a   [10] = '{32'd5, 32'hF0F0_F0F0, 32'h0000_000F, 32'hAAAA_5555, 32'd1,
                                  32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'd9};
  logic [DW-1:0] alu_b   [10] = '{32'd7, 32'hFF00_FF00, 32'h0000_00F0, 32'hFFFF_0000, 32'd35,
                                  32'd4, 32'd4, 32'd1, 32'h0000_1234, 32'd3};
  logic [DW-1:0] alu_exp [10] = '{32'hFFFF_FFFE, 32'hF000_F000, 32'h0000_00FF, 32'h5555_5555, 32'd8,
                                  32'h0800_0000, 32'hF800_0000, 32'd1, 32'h0000_1234, 32'd0};

  initial begin
    logic [IN_W-1:0]  b_a, b_b;
    logic [OUT_W:0]   e_a, e_b;
    int               n;

    rst              = 1'b1;
    id_to_exe_valid  = 1'b0;
    id_to_exe_bus    = '0;
    mem_to_exe_ready = 1'b1;
    dmem_req_ready   = 1'b0;
    dmem_rsp_valid   = 1'b0;
    dmem_rdata       = '0;
    tick();
    tick();

    // reset state
    check("rst_valid",    exe_to_mem_valid, 1'b0);
    check("rst_req",      dmem_req_valid, 1'b0);
    check("rst_regw",     exe_to_mem_bus[OUT_W-1], 1'b0);
    check("rst_misalign", exe_misalign, 1'b0);
    check("rst_state",    dbg_state, S_EMPTY);
    check("rst_id_ready", exe_to_id_ready, 1'b1);
    rst = 1'b0;
    tick();

    // add: single-cycle latency
    exp_q.push_back(mk_out(1'b0, 1'b1, 5'd3, 32'd12, LD_NONE, '0));
    drive_id(mk_in(1'b1, 5'd3, ALU_ADD, 32'd5, 32'd7, '0, LD_NONE, ST_NONE));
    check("add_latency", exe_to_mem_valid, 1'b1);
    tick();

    // ALU ops back-to-back
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk_out(1'b0, 1'b1, RA'(i + 1), alu_exp[i], LD_NONE, '0));
      drive_id(mk_in(1'b1, RA'(i + 1), alu_ops[i], alu_a[i], alu_b[i], '0, LD_NONE, ST_NONE));
    end
    tick();

    // lbu at byte 3 with delayed request handshake
    exp_q.push_back(mk_out(1'b0, 1'b1, 5'd9, 32'h8000_0003, LD_LBU, 32'h0000_00AA));
    drive_id(mk_in(1'b1, 5'd9, ALU_ADD, 32'h8000_0000, 32'd3, '0, LD_LBU, ST_NONE));
    mem_serve("lbu", 2, 0, 32'hAABB_CCDD, 32'h8000_0000, 1'b0, 4'b0000, '0);
    tick();

    // sh to upper half
    exp_q.push_back(mk_out(1'b0, 1'b0, 5'd0, 32'h0000_0102, LD_NONE, '0));
    drive_id(mk_in(1'b0, 5'd0, ALU_ADD, 32'h100, 32'd2, 32'h1234, LD_NONE, ST_SH));
    mem_serve("sh", 0, 1, $urandom, 32'h100, 1'b1, 4'b1100, 32'h1234_0000);
    tick();

    // sb to byte 3
    exp_q.push_back(mk_out(1'b0, 1'b0, 5'd0, 32'h0000_0043, LD_NONE, '0));
    drive_id(mk_in(1'b0, 5'd0, ALU_ADD, 32'h40, 32'd3, 32'h0000_00EF, LD_NONE, ST_SB));
    mem_serve("sb", 1, 0, $urandom, 32'h40, 1'b1, 4'b1000, 32'hEF00_0000);
    tick();

    // load+store both set: store wins, load_inst forced to 0
    exp_q.push_back(mk_out(1'b0, 1'b1, 5'd7, 32'h0000_0040, LD_NONE, '0));
    drive_id(mk_in(1'b1, 5'd7, ALU_SUB, 32'h40, 32'd0, 32'hCAFE_BABE, LD_LB, ST_SW));
    mem_serve("sw_prio", 0, 0, 32'h5555_AAAA, 32'h40, 1'b1, 4'b1111, 32'hCAFE_BABE);
    tick();

    // misaligned lw, then sltu
    exp_q.push_back(mk_out(1'b1, 1'b1, 5'd4, 32'h0000_0101, LD_LW, 32'h0011_2233));
    drive_id(mk_in(1'b1, 5'd4, ALU_ADD, 32'h100, 32'd1, '0, LD_LW, ST_NONE));
    mem_serve("lw_mis", 0, 0, 32'h1122_3344, 32'h100, 1'b0, 4'b0000, '0);
    tick();
    exp_q.push_back(mk_out(1'b0, 1'b1, 5'd5, 32'd1, LD_NONE, '0));
    drive_id(mk_in(1'b1, 5'd5, ALU_SLTU, 32'd1, 32'hFFFF_FFFF, '0, LD_NONE, ST_NONE));
    tick();

    // misaligned sh at byte 3: strobe/data truncated to the word
    exp_q.push_back(mk_out(1'b1, 1'b0, 5'd0, 32'h0000_0103, LD_NONE, '0));
    drive_id(mk_in(1'b0, 5'd0, ALU_ADD, 32'h100, 32'd3, 32'h1234, LD_NONE, ST_SH));
    mem_serve("sh_mis", 0, 0, $urandom, 32'h100, 1'b1, 4'b1000, 32'h3400_0000);
    tick();

    // backpressure with next instruction pending
    b_a = mk_in(1'b1, 5'd10, ALU_OR, 32'h00FF_0000, 32'h0000_00FF, '0, LD_NONE, ST_NONE);
    e_a = mk_out(1'b0, 1'b1, 5'd10, 32'h00FF_00FF, LD_NONE, '0);
    b_b = mk_in(1'b1, 5'd11, ALU_XOR, 32'hFFFF_FFFF, 32'h0F0F_0F0F, '0, LD_NONE, ST_NONE);
    e_b = mk_out(1'b0, 1'b1, 5'd11, 32'hF0F0_F0F0, LD_NONE, '0);
    mem_to_exe_ready = 1'b0;
    exp_q.push_back(e_a);
    drive_id(b_a);
    exp_q.push_back(e_b);
    id_to_exe_valid = 1'b1;
    id_to_exe_bus   = b_b;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_id_ready", exe_to_id_ready, 1'b0);
      check("bp_valid",    exe_to_mem_valid, 1'b1);
      check("bp_bus",      exe_to_mem_bus, e_a[OUT_W-1:0]);
      tick();
    end
    mem_to_exe_ready = 1'b1;
    #1;
    check("bp_release_ready", exe_to_id_ready, 1'b1);
    tick();
    id_to_exe_valid = 1'b0;
    #1;
    check("bp_b2b_valid", exe_to_mem_valid, 1'b1);
    check("bp_b2b_bus",   exe_to_mem_bus, e_b[OUT_W-1:0]);
    tick();

    // reset while waiting for a load response
    drive_id(mk_in(1'b1, 5'd12, ALU_ADD, 32'h200, 32'd0, '0, LD_LW, ST_NONE));
    dmem_req_ready = 1'b1;
    #1;
    check("rstw_req_valid", dmem_req_valid, 1'b1);
    tick();
    dmem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rstw_in_wait", dbg_state, S_WAIT);
    tick();
    rst            = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'h7777_7777;
    #1;
    check("rstw_state", dbg_state, S_EMPTY);
    check("rstw_valid", exe_to_mem_valid, 1'b0);
    check("rstw_req",   dmem_req_valid, 1'b0);
    tick();
    dmem_rsp_valid = 1'b0;
    #1;
    check("rstw_late_rsp_state", dbg_state, S_EMPTY);
    check("rstw_late_rsp_valid", exe_to_mem_valid, 1'b0);
    exp_q.push_back(mk_out(1'b0, 1'b1, 5'd13, 32'd30, LD_NONE, '0));
    drive_id(mk_in(1'b1, 5'd13, ALU_ADD, 32'd10, 32'd20, '0, LD_NONE, ST_NONE));
    check("rstw_next_valid", exe_to_mem_valid, 1'b1);
    tick();

    // drain
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
